// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch path: FSM state type, HALT opcode, default reset PC
// and the wrapping PC increment.
package cpu_pkg;

    typedef enum logic [0:0] {
        StRun,
        StHalted
    } fetch_state_e;

    localparam logic [3:0]  HALT_OPCODE      = 4'hF;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    // Sequential fetch wraps to word 0 after the last instruction-memory word.
    function automatic logic [15:0] pc_incr(input logic [15:0] pc, input logic [15:0] last);
        return (pc == last) ? 16'h0000 : pc + 16'h0001;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid slot holding an instruction and its PC while decode applies backpressure.
// Flush wins over load, load wins over pop.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        pop,
    input  logic        flush,
    input  logic [15:0] load_data,
    input  logic [15:0] load_pc,
    output logic [15:0] data,
    output logic [15:0] pc,
    output logic        valid
);

    logic        valid_q, valid_d;
    logic [15:0] data_q, pc_q;

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= 16'h0000;
            pc_q    <= 16'h0000;
        end else begin
            valid_q <= valid_d;
            if (load && !flush) begin
                data_q <= load_data;
                pc_q   <= load_pc;
            end
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, one-deep inflight tracking and a skid slot toward decode.
// HALT-opcode detection is built only when FETCH_HALT_EN is defined.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_addr,
    output logic        imem_en,
    input  logic [15:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc,
    output logic        halted
);

    localparam logic [15:0] PC_LAST = 16'(IMEM_DEPTH - 1);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  infl_pc_q;
    logic         infl_q, infl_d;
    logic         skid_valid, skid_load, skid_pop;
    logic [15:0]  skid_data, skid_pc;
    logic         present_valid, handshake, issue, halt_seen;

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .pop       (skid_pop),
        .flush     (redirect_valid),
        .load_data (imem_instr),
        .load_pc   (infl_pc_q),
        .data      (skid_data),
        .pc        (skid_pc),
        .valid     (skid_valid)
    );

    // Skid and inflight are mutually exclusive, so skid simply takes precedence.
    assign present_valid = skid_valid | infl_q;
    assign out_instr     = skid_valid ? skid_data : imem_instr;
    assign out_pc        = skid_valid ? skid_pc : infl_pc_q;
    assign out_valid     = rst_n & ~redirect_valid & present_valid;
    assign handshake     = out_valid & out_ready;

`ifdef FETCH_HALT_EN
    assign halt_seen = present_valid & (out_instr[15:12] == HALT_OPCODE);
    assign halted    = rst_n & (state_q == StHalted);
`else
    assign halt_seen = 1'b0;
    assign halted    = 1'b0;
`endif

    assign issue = (state_q == StRun) & ~redirect_valid & ~skid_valid
                 & (~infl_q | out_ready) & ~halt_seen;

    assign imem_en   = rst_n & issue;
    assign imem_addr = pc_q;
    assign skid_load = infl_q & ~skid_valid & ~out_ready;
    assign skid_pop  = handshake & skid_valid;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        infl_d  = issue;
        if (redirect_valid) begin
            state_d = StRun;
            pc_d    = redirect_pc & PC_LAST;
        end else begin
            if (issue) begin
                pc_d = pc_incr(pc_q, PC_LAST);
            end
            if (handshake && halt_seen) begin
                state_d = StHalted;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StRun;
            pc_q      <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            infl_q  <= infl_d;
            if (issue) begin
                infl_pc_q <= pc_q;
            end
        end
    end

endmodule
